// File: rtl/axi_pm_pkg.sv
`default_nettype none
// =====================================================================
// Module      : axi_pm_pkg
// Description : Shared types and AXI constants for the packet mover.
// Revision    : 1.0
// =====================================================================
package axi_pm_pkg;

   typedef enum logic [2:0] {
      WRB_IDLE      = 3'd0,
      WRB_WAIT_DATA = 3'd1,
      WRB_ADDR      = 3'd2,
      WRB_DATA      = 3'd3,
      WRB_RESP      = 3'd4
   } wrb_state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam int         AXI_4K_BYTES   = 4096;

   // Burst length width: holds 1..256 beats
   localparam int         c_blen_w       = 9;

endpackage
`default_nettype wire

// File: rtl/burst_len_calc.sv
`default_nettype none
// =====================================================================
// Module      : burst_len_calc
// Description : Combinational burst length: min(remaining, MAX_BURST,
//               beats to next 4 KB boundary when AXI_4K_SPLIT_EN).
// Revision    : 1.0
// =====================================================================
module burst_len_calc
   import axi_pm_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 8
) (
   input  logic [15:0]         remaining,
   input  logic [ADDR_W-1:0]   addr,
   output logic [c_blen_w-1:0] blen
);

   localparam int c_size = $clog2(DATA_W/8);

   logic [c_blen_w-1:0] w_blen;
   logic                w_unused_addr;

`ifdef AXI_4K_SPLIT_EN
   logic [12:0] w_bytes_4k;
   logic [12:0] w_beats_4k;

   // Address is beat-aligned, so at least one beat always fits
   assign w_bytes_4k    = 13'(AXI_4K_BYTES) - {1'b0, addr[11:0]};
   assign w_beats_4k    = w_bytes_4k >> c_size;
   assign w_unused_addr = ^addr[ADDR_W-1:12];
`else
   assign w_unused_addr = ^addr;
`endif

   always_comb begin
      w_blen = c_blen_w'(MAX_BURST);
      if (remaining < 16'(MAX_BURST)) begin
         w_blen = c_blen_w'(remaining);
      end
`ifdef AXI_4K_SPLIT_EN
      if (w_beats_4k < 13'(w_blen)) begin
         w_blen = c_blen_w'(w_beats_4k);
      end
`endif
   end

   assign blen = w_blen;

endmodule
`default_nettype wire

// File: rtl/axi_wr_burst_ctrl.sv
`default_nettype none
// =====================================================================
// Module      : axi_wr_burst_ctrl
// Description : Drains the payload FIFO into AXI4 write bursts, starting
//               each burst only once the FIFO holds all of its beats.
//               Optional 4 KB burst splitting: AXI_4K_SPLIT_EN.
// Revision    : 1.0
// =====================================================================
module axi_wr_burst_ctrl
   import axi_pm_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int MAX_BURST  = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [ADDR_W-1:0]              cmd_addr,
   input  logic [15:0]                    cmd_beats,
   input  logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
   input  logic [DATA_W-1:0]              fifo_rd_data,
   output logic                           fifo_rd_en,
   output logic                           awvalid,
   input  logic                           awready,
   output logic [ADDR_W-1:0]              awaddr,
   output logic [7:0]                     awlen,
   output logic [2:0]                     awsize,
   output logic [1:0]                     awburst,
   output logic                           wvalid,
   input  logic                           wready,
   output logic [DATA_W-1:0]              wdata,
   output logic [DATA_W/8-1:0]            wstrb,
   output logic                           wlast,
   input  logic                           bvalid,
   output logic                           bready,
   input  logic [1:0]                     bresp,
   output logic                           done,
   output logic                           err
);

   localparam int c_bytes = DATA_W/8;
   localparam int c_size  = $clog2(c_bytes);

   wrb_state_t          r_state, w_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [15:0]         r_remaining;
   logic [c_blen_w-1:0] r_beat;
   logic [c_blen_w-1:0] w_blen;
   logic                r_done, r_err;
   logic                w_accept, w_last_beat, w_fifo_ok, w_cmd_last;

   burst_len_calc #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST)
   ) u_blen (
      .remaining (r_remaining),
      .addr      (r_addr),
      .blen      (w_blen)
   );

   assign w_accept    = cmd_valid && (r_state == WRB_IDLE);
   assign w_last_beat = (r_beat == w_blen - 1'b1);
   assign w_fifo_ok   = 32'(fifo_level) >= 32'(w_blen);
   assign w_cmd_last  = (r_remaining == 16'(w_blen));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= WRB_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      cmd_ready  = 1'b0;
      awvalid    = 1'b0;
      awaddr     = '0;
      awlen      = '0;
      wvalid     = 1'b0;
      wdata      = '0;
      wstrb      = '0;
      wlast      = 1'b0;
      fifo_rd_en = 1'b0;
      bready     = 1'b0;
      case (r_state)
         WRB_IDLE: begin
            cmd_ready = 1'b1;
            // Zero-beat commands complete from IDLE without any AXI traffic
            if (cmd_valid && (cmd_beats != 16'd0)) w_next = WRB_WAIT_DATA;
         end
         WRB_WAIT_DATA: begin
            if (w_fifo_ok) w_next = WRB_ADDR;
         end
         WRB_ADDR: begin
            awvalid = 1'b1;
            awaddr  = r_addr;
            awlen   = 8'(w_blen - 1'b1);
            if (awready) w_next = WRB_DATA;
         end
         WRB_DATA: begin
            wvalid     = 1'b1;
            wdata      = fifo_rd_data;
            wstrb      = '1;
            wlast      = w_last_beat;
            fifo_rd_en = wready;
            if (wready && w_last_beat) w_next = WRB_RESP;
         end
         WRB_RESP: begin
            bready = 1'b1;
            if (bvalid) w_next = w_cmd_last ? WRB_IDLE : WRB_WAIT_DATA;
         end
         default: w_next = WRB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr      <= '0;
         r_remaining <= '0;
         r_beat      <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            WRB_IDLE: begin
               if (w_accept) begin
                  r_addr      <= cmd_addr & ~ADDR_W'(c_bytes - 1);
                  r_remaining <= cmd_beats;
                  r_beat      <= '0;
                  r_err       <= 1'b0;
                  r_done      <= (cmd_beats == 16'd0);
               end
            end
            WRB_DATA: begin
               if (wready) r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
            end
            WRB_RESP: begin
               if (bvalid) begin
                  r_err       <= r_err | (bresp != AXI_RESP_OKAY);
                  r_remaining <= r_remaining - 16'(w_blen);
                  r_addr      <= r_addr + (ADDR_W'(w_blen) << c_size);
                  r_done      <= w_cmd_last;
               end
            end
            default: ;
         endcase
      end
   end

   assign awsize  = 3'(c_size);
   assign awburst = AXI_BURST_INCR;
   assign done    = r_done;
   assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_burst_ctrl.sv
`default_nettype none
// =====================================================================
// Module      : tb_axi_wr_burst_ctrl
// Description : Directed, table-driven bench for axi_wr_burst_ctrl.
// Revision    : 1.0
// =====================================================================
module tb_axi_wr_burst_ctrl;

   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 32;
   localparam int FIFO_DEPTH = 16;
   localparam int MAX_BURST  = 8;
   localparam int LVL_W      = $clog2(FIFO_DEPTH+1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_valid, cmd_ready;
   logic [ADDR_W-1:0] cmd_addr;
   logic [15:0]       cmd_beats;
   logic [LVL_W-1:0]  fifo_level;
   logic [DATA_W-1:0] fifo_rd_data;
   logic              fifo_rd_en;
   logic              awvalid, awready;
   logic [ADDR_W-1:0] awaddr;
   logic [7:0]        awlen;
   logic [2:0]        awsize;
   logic [1:0]        awburst;
   logic              wvalid, wready;
   logic [DATA_W-1:0] wdata;
   logic [3:0]        wstrb;
   logic              wlast;
   logic              bvalid, bready;
   logic [1:0]        bresp;
   logic              done, err;

   always #5 clk = ~clk;

   axi_wr_burst_ctrl #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_BURST(MAX_BURST)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
      .fifo_level(fifo_level), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
      .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
      .awsize(awsize), .awburst(awburst),
      .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
      .bvalid(bvalid), .bready(bready), .bresp(bresp),
      .done(done), .err(err)
   );

   // FIFO source model: fifo_avail words remain, level saturates at depth
   int          fifo_avail;
   logic [31:0] fifo_head;
   assign fifo_level   = (fifo_avail > FIFO_DEPTH) ? LVL_W'(FIFO_DEPTH) : LVL_W'(fifo_avail);
   assign fifo_rd_data = fifo_head;

   typedef struct {
      logic [31:0]      addr;
      logic [15:0]      beats;
      bit               tog;
      int               err_burst;
      int               n;
      logic [2:0][31:0] a;
      logic [2:0][7:0]  l;
      bit               exp_err;
   } vec_t;

   vec_t vecs[7];

   int n_checks = 0, n_fail = 0;
   int n_aw, n_w, n_b, n_done, proto_err, wdata_err, wlast_err, err_burst;
   int cyc = 0, accept_cyc, first_aw_cyc, beat;
   logic [31:0] aw_a[4];
   logic [7:0]  aw_l[4];
   logic [7:0]  cur_len;
   logic [31:0] exp_wdata, seed = 32'hD000_0000;
   logic        err_seen;
   bit          toggle;
   bit          p_aw_hs, p_wl_hs, p_b_hs, p_acc, p_aw_wait, p_w_wait;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Observe at negedge, advance one clock, update the responders
   task automatic step();
      logic aw_hs, w_hs, b_hs, acc;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      b_hs  = bvalid && bready;
      acc   = cmd_valid && cmd_ready;
      if (awvalid && wvalid) proto_err++;
      if (fifo_rd_en !== w_hs) proto_err++;
      if (p_aw_hs && !wvalid) proto_err++;
      if (p_wl_hs && !bready) proto_err++;
      if (p_aw_wait && !awvalid) proto_err++;
      if (p_w_wait && !wvalid) proto_err++;
      if (done) begin
         n_done++;
         err_seen = err;
         if (!(p_b_hs || p_acc)) proto_err++;
      end
      if (acc) accept_cyc = cyc;
      if (awvalid && first_aw_cyc < 0) first_aw_cyc = cyc;
      if (aw_hs) begin
         if (n_aw < 4) begin
            aw_a[n_aw] = awaddr;
            aw_l[n_aw] = awlen;
         end
         n_aw++;
         cur_len = awlen;
         beat = 0;
      end
      if (w_hs) begin
         if (wdata !== exp_wdata) wdata_err++;
         if (wstrb !== 4'hF) proto_err++;
         if (wlast !== (beat == int'(cur_len))) wlast_err++;
         exp_wdata++;
         beat++;
         n_w++;
      end
      p_aw_hs = aw_hs; p_wl_hs = w_hs && wlast; p_b_hs = b_hs; p_acc = acc;
      p_aw_wait = awvalid && !awready; p_w_wait = wvalid && !wready;
      @(posedge clk);
      #1;
      if (w_hs) begin
         fifo_head++;
         fifo_avail--;
      end
      if (b_hs) n_b++;
      bresp   = (n_b == err_burst) ? 2'b10 : 2'b00;
      wready  = toggle ? ~wready : 1'b1;
      awready = toggle ? ~awready : 1'b1;
      @(negedge clk);
      cyc++;
   endtask

   task automatic start_cmd(input logic [31:0] addr, input logic [15:0] beats, input int fill,
                            input bit tog, input int eb);
      n_aw = 0; n_w = 0; n_b = 0; n_done = 0; proto_err = 0; wdata_err = 0; wlast_err = 0;
      err_seen = 1'b0; accept_cyc = -1; first_aw_cyc = -1; beat = 0; cur_len = '0;
      p_aw_hs = 0; p_wl_hs = 0; p_b_hs = 0; p_acc = 0; p_aw_wait = 0; p_w_wait = 0;
      seed += 32'h100;
      fifo_head = seed; exp_wdata = seed; fifo_avail = fill;
      toggle = tog; wready = 1'b1; awready = 1'b0;
      err_burst = eb; bresp = (eb == 0) ? 2'b10 : 2'b00;
      cmd_addr = addr; cmd_beats = beats; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic finish_cmd();
      for (int i = 0; i < 300 && n_done == 0; i++) step();
      repeat (3) step();
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_cmd_ready"}, cmd_ready, 1);
      check({tag, "_awvalid"}, awvalid, 0);
      check({tag, "_wvalid"}, wvalid, 0);
      check({tag, "_bready"}, bready, 0);
      check({tag, "_fifo_rd_en"}, fifo_rd_en, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, err, 0);
      check({tag, "_awaddr"}, awaddr, 0);
      check({tag, "_awlen"}, awlen, 0);
      check({tag, "_wlast"}, wlast, 0);
      check({tag, "_wdata"}, wdata, 0);
      check({tag, "_awsize"}, awsize, 2);
      check({tag, "_awburst"}, awburst, 1);
   endtask

   task automatic add_vec(input int i, input logic [31:0] addr, input logic [15:0] beats,
                          input bit tog, input int eb, input int n,
                          input logic [31:0] a0, input logic [7:0] l0,
                          input logic [31:0] a1, input logic [7:0] l1,
                          input logic [31:0] a2, input logic [7:0] l2, input bit e);
      vecs[i].addr = addr; vecs[i].beats = beats; vecs[i].tog = tog; vecs[i].err_burst = eb;
      vecs[i].n = n; vecs[i].exp_err = e;
      vecs[i].a[0] = a0; vecs[i].a[1] = a1; vecs[i].a[2] = a2;
      vecs[i].l[0] = l0; vecs[i].l[1] = l1; vecs[i].l[2] = l2;
   endtask

   task automatic run_vec(input int i, input string tag);
      start_cmd(vecs[i].addr, vecs[i].beats, int'(vecs[i].beats), vecs[i].tog, vecs[i].err_burst);
      finish_cmd();
      check({tag, "_n_aw"}, n_aw, vecs[i].n);
      for (int b = 0; b < vecs[i].n && b < 3; b++) begin
         check($sformatf("%s_awaddr%0d", tag, b), aw_a[b], vecs[i].a[b]);
         check($sformatf("%s_awlen%0d", tag, b), aw_l[b], vecs[i].l[b]);
      end
      check({tag, "_pops"}, n_w, vecs[i].beats);
      check({tag, "_done_cnt"}, n_done, 1);
      check({tag, "_err"}, err_seen, vecs[i].exp_err);
      check({tag, "_wdata_order"}, wdata_err, 0);
      check({tag, "_wlast"}, wlast_err, 0);
      check({tag, "_protocol"}, proto_err, 0);
      if (vecs[i].beats != 16'd0) check({tag, "_aw_latency"}, first_aw_cyc - accept_cyc, 2);
   endtask

   initial begin
      bit saw;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_beats = '0;
      fifo_avail = 0; fifo_head = '0; awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
      toggle = 0; err_burst = -1;

      add_vec(0, 32'h1000, 16'd20, 0, -1, 3, 32'h1000, 8'd7, 32'h1020, 8'd7, 32'h1040, 8'd3, 0);
`ifdef AXI_4K_SPLIT_EN
      add_vec(1, 32'h0FF8, 16'd8, 0, -1, 2, 32'h0FF8, 8'd1, 32'h1000, 8'd5, 32'h0, 8'd0, 0);
      add_vec(6, 32'hFFFF_FFF0, 16'd8, 0, -1, 2, 32'hFFFF_FFF0, 8'd3, 32'h0, 8'd3, 32'h0, 8'd0, 0);
`else
      add_vec(1, 32'h0FF8, 16'd8, 0, -1, 1, 32'h0FF8, 8'd7, 32'h0, 8'd0, 32'h0, 8'd0, 0);
      add_vec(6, 32'hFFFF_FFF0, 16'd8, 0, -1, 1, 32'hFFFF_FFF0, 8'd7, 32'h0, 8'd0, 32'h0, 8'd0, 0);
`endif
      add_vec(2, 32'h2000, 16'd16, 0, 0, 2, 32'h2000, 8'd7, 32'h2020, 8'd7, 32'h0, 8'd0, 1);
      add_vec(3, 32'h3003, 16'd5, 0, -1, 1, 32'h3000, 8'd4, 32'h0, 8'd0, 32'h0, 8'd0, 0);
      add_vec(4, 32'h0, 16'd0, 0, -1, 0, 32'h0, 8'd0, 32'h0, 8'd0, 32'h0, 8'd0, 0);
      add_vec(5, 32'h6000, 16'd8, 1, -1, 1, 32'h6000, 8'd7, 32'h0, 8'd0, 32'h0, 8'd0, 0);

      repeat (3) @(negedge clk);
      check_reset("rst");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) run_vec(i, $sformatf("v%0d", i));

      // FIFO throttle: 4-beat burst, only 3 words available
      start_cmd(32'h4000, 16'd4, 3, 0, -1);
      cmd_valid = 1'b1; cmd_beats = 16'd99;
      check("thr_cmd_ready_busy", cmd_ready, 0);
      saw = 0;
      repeat (5) begin
         step();
         if (awvalid) saw = 1;
      end
      cmd_valid = 1'b0;
      check("thr_no_awvalid", saw, 0);
      fifo_avail = 4;
      check("thr_aw_before", awvalid, 0);
      step();
      check("thr_aw_after", awvalid, 1);
      finish_cmd();
      check("thr_n_aw", n_aw, 1);
      check("thr_awlen", aw_l[0], 3);
      check("thr_pops", n_w, 4);
      check("thr_done_cnt", n_done, 1);

      // Reset in the middle of the DATA phase
      start_cmd(32'h5000, 16'd8, 8, 0, -1);
      for (int i = 0; i < 50 && n_w < 3; i++) step();
      check("mid_beats_taken", n_w, 3);
      check("mid_wvalid", wvalid, 1);
      rst_n = 1'b0;
      #1;
      check_reset("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_vec(0, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
